// File: rtl/key_step_conditioner.sv
// Debounced pushbutton step generator: synchronizes KEY_n and w_raw, filters bounce on press and
// release, and emits one registered step pulse plus the captured data bit per accepted press.
module key_step_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       KEY_n,
  input  logic       w_raw,
  output logic       step,
  output logic       w,
  output logic       pressed,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {StIdle, StPressWait, StPressed, StReleaseWait} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       key_sync_q, w_sync_q;
  logic             key_s, w_s;
  logic             accept;

  logic             step_d, w_d, pressed_d;
  logic [7:0]       press_count_d;

  // Synchronizers reset high so the key reads as released after reset.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      key_sync_q <= 2'b11;
      w_sync_q   <= 2'b11;
    end else begin
      key_sync_q <= {key_sync_q[0], KEY_n};
      w_sync_q   <= {w_sync_q[0], w_raw};
    end
  end

  assign key_s = key_sync_q[1];
  assign w_s   = w_sync_q[1];

  // State register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!key_s) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (key_s) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          state_d = StPressed;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPressed: begin
        if (key_s) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end
      end
      StReleaseWait: begin
        if (!key_s) begin
          state_d = StPressed;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic, computed from the transition so the registered outputs align with the state.
  always_comb begin
    step_d        = accept;
    w_d           = accept ? w_s : w;
    pressed_d     = (state_d == StPressed) || (state_d == StReleaseWait);
    press_count_d = accept ? press_count + 8'd1 : press_count;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      step        <= 1'b0;
      w           <= 1'b0;
      pressed     <= 1'b0;
      press_count <= 8'd0;
    end else begin
      step        <= step_d;
      w           <= w_d;
      pressed     <= pressed_d;
      press_count <= press_count_d;
    end
  end

endmodule

// File: tb/tb_key_step_conditioner.sv
// Bench for key_step_conditioner: directed and random key activity checked against a
// run-length debounce model (a level flips after D+1 consecutive opposite synchronized samples).
module tb_key_step_conditioner;

  localparam int D = 4;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       KEY_n;
  logic       w_raw;
  logic       step;
  logic       w;
  logic       pressed;
  logic [7:0] press_count;

  key_step_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .KEY_n      (KEY_n),
    .w_raw      (w_raw),
    .step       (step),
    .w          (w),
    .pressed    (pressed),
    .press_count(press_count)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;
  int steps_seen = 0;

  // Reference model state.
  bit       m_acc;
  int       m_run;
  bit       mk1, mk2, mw1, mw2;
  bit       e_step, e_w, e_pressed;
  bit [7:0] e_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_run = 0;
    mk1 = 1; mk2 = 1; mw1 = 1; mw2 = 1;
    e_step = 0; e_w = 0; e_pressed = 0; e_cnt = 0;
  endtask

  task automatic model_edge();
    e_step = 0;
    if (m_acc ? (mk2 == 1'b1) : (mk2 == 1'b0)) begin
      m_run++;
      if (m_run == D + 1) begin
        m_acc = !m_acc;
        m_run = 0;
        if (m_acc) begin
          e_step = 1;
          e_w    = mw2;
          e_cnt  = e_cnt + 8'd1;
        end
      end
    end else begin
      m_run = 0;
    end
    e_pressed = m_acc;
    mk2 = mk1; mk1 = KEY_n;
    mw2 = mw1; mw1 = w_raw;
  endtask

  task automatic tick();
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
    check("step", step, e_step);
    check("w", w, e_w);
    check("pressed", pressed, e_pressed);
    check("press_count", press_count, e_cnt);
    if (step === 1'b1) steps_seen++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Edges until step (want_fall=0) or until pressed drops (want_fall=1); bounded.
  task automatic edges_until(input bit want_fall, output int n);
    bit done;
    n = 0;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      n++;
      if (!want_fall && step === 1'b1) done = 1;
      if (want_fall && pressed === 1'b0) done = 1;
    end
    if (!done) n = 999;
  endtask

  task automatic apply_reset();
    @(negedge Clock);
    Resetn = 0;
    model_reset();
    #1;
    check("rst_step", step, 0);
    check("rst_w", w, 0);
    check("rst_pressed", pressed, 0);
    check("rst_count", press_count, 0);
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1;
  endtask

  initial begin
    int lat;
    int base;
    Resetn = 1; KEY_n = 1; w_raw = 0;
    model_reset();
    apply_reset();
    ticks(3);

    // Clean press with w_raw=1.
    KEY_n = 0; w_raw = 1;
    edges_until(0, lat);
    check("clean_latency", lat, D + 3);
    check("clean_w", w, 1);
    check("clean_count", press_count, 1);
    check("clean_pressed", pressed, 1);
    tick();
    check("clean_one_cycle", step, 0);
    KEY_n = 1;
    ticks(12);

    // Press bounce.
    base = steps_seen;
    KEY_n = 0; ticks(3);
    KEY_n = 1; ticks(1);
    KEY_n = 0; w_raw = 0;
    edges_until(0, lat);
    check("bounce_latency", lat, D + 3);
    check("bounce_steps", steps_seen - base, 1);

    // Long hold while w_raw toggles: no further steps, w frozen.
    base = steps_seen;
    for (int i = 0; i < 20; i++) begin
      w_raw = ~w_raw;
      ticks(5);
    end
    check("hold_steps", steps_seen - base, 0);
    check("hold_w", w, 0);

    // Release bounce.
    KEY_n = 1; ticks(2);
    KEY_n = 0; ticks(1);
    KEY_n = 1;
    edges_until(1, lat);
    check("release_latency", lat, D + 3);
    check("release_steps", steps_seen - base, 0);
    ticks(5);

    // 256 + 1 clean presses with random data.
    apply_reset();
    ticks(2);
    base = steps_seen;
    for (int p = 0; p < 257; p++) begin
      KEY_n = 0; w_raw = 1'($urandom);
      edges_until(0, lat);
      ticks($urandom_range(0, 3));
      KEY_n = 1; w_raw = 1'($urandom);
      edges_until(1, lat);
      ticks($urandom_range(0, 3));
      if (p == 255) check("wrap_count", press_count, 0);
    end
    check("wrap_steps", steps_seen - base, 257);
    check("wrap_plus_one", press_count, 1);

    // Reset during the press debounce, key kept held.
    KEY_n = 0;
    ticks(5);
    apply_reset();
    base = steps_seen;
    edges_until(0, lat);
    check("post_reset_latency", lat, D + 3);
    check("post_reset_count", press_count, 1);
    KEY_n = 1;
    ticks(12);

    // Random bouncy activity.
    for (int i = 0; i < 150; i++) begin
      KEY_n = 1'($urandom);
      w_raw = 1'($urandom);
      ticks($urandom_range(1, 9));
    end
    KEY_n = 1;
    ticks(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
